// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out frame transmitter: start bit, WIDTH data bits, optional
// parity bit, stop bit. All state moves on the falling edge of clk_n, gated by CE.
module piso_serial_tx #(
    parameter int WIDTH      = 8,
    parameter int LSB_FIRST  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk_n,
    input  logic             clr_n,
    input  logic             CE,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    output logic             ready,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               par_q, par_d;
    logic               ser_q, ser_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? {1'b0, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b0};
    endfunction

    // The accumulator holds even parity of the data bits; odd sense inverts it.
    function automatic logic parity_bit(input logic acc);
        return acc ^ (PARITY_ODD != 0);
    endfunction

    // Next-state, shift path and registered-output decode.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        ser_d   = ser_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (CE && load) begin
                    shreg_d = D;
                    par_d   = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                    ser_d   = 1'b0;
                    state_d = S_START;
                end else begin
                    ser_d   = 1'b1;
                end
            end
            S_START: begin
                if (CE) begin
                    ser_d   = head_bit(shreg_q);
                    par_d   = par_q ^ head_bit(shreg_q);
                    shreg_d = shift_word(shreg_q);
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_DATA;
                end else begin
                    ser_d   = 1'b0;
                end
            end
            S_DATA: begin
                if (!CE) begin
                    ser_d = ser_q;
                end else if (cnt_q == CNT_W'(WIDTH)) begin
                    if (PARITY_EN != 0) begin
                        ser_d   = parity_bit(par_q);
                        state_d = S_PARITY;
                    end else begin
                        ser_d   = 1'b1;
                        state_d = S_STOP;
                    end
                end else begin
                    ser_d   = head_bit(shreg_q);
                    par_d   = par_q ^ head_bit(shreg_q);
                    shreg_d = shift_word(shreg_q);
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (CE) begin
                    ser_d   = 1'b1;
                    state_d = S_STOP;
                end else begin
                    ser_d   = ser_q;
                end
            end
            S_STOP: begin
                if (!CE) begin
                    ser_d = 1'b1;
                end else if (load) begin
                    done_d  = 1'b1;
                    shreg_d = D;
                    par_d   = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                    ser_d   = 1'b0;
                    state_d = S_START;
                end else begin
                    done_d  = 1'b1;
                    ser_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                ser_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d == S_IDLE) || (state_d == S_STOP);
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers; clr_n abandons any frame in flight.
    always_ff @(negedge clk_n or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
            shreg_q <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            par_q   <= 1'b0;
            ser_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            ser_q   <= ser_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ser_out = ser_q;
    assign ready   = ready_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: three instances (no parity, even, odd) share stimulus;
// a monitor collects each frame bit per CE interval and compares at the done pulse.
`timescale 1ns/1ps
module tb_piso_serial_tx;

    logic       clk_n = 1'b1;
    logic       clr_n = 1'b1;
    logic       CE;
    logic       load;
    logic [7:0] D;
    logic [2:0] ready_w, ser_w, busy_w, done_w;

    int    tests = 0;
    int    fails = 0;
    int    phase = 0;
    logic  ce_hold = 1'b0;
    string exp_q0[$];
    string exp_q1[$];
    string exp_q2[$];
    string got[3];
    string mon_exp;
    logic  mon_have;
    logic [2:0] done_prev = 3'b000;

    piso_serial_tx #(.WIDTH(8), .LSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0)) u_plain (
        .clk_n(clk_n), .clr_n(clr_n), .CE(CE), .load(load), .D(D),
        .ready(ready_w[0]), .ser_out(ser_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    piso_serial_tx #(.WIDTH(8), .LSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
        .clk_n(clk_n), .clr_n(clr_n), .CE(CE), .load(load), .D(D),
        .ready(ready_w[1]), .ser_out(ser_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    piso_serial_tx #(.WIDTH(8), .LSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk_n(clk_n), .clr_n(clr_n), .CE(CE), .load(load), .D(D),
        .ready(ready_w[2]), .ser_out(ser_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    always #5 clk_n = ~clk_n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Inputs change 1ns after the falling edge; CE pulses every 4th clock.
    task automatic step();
        @(negedge clk_n);
        #1;
        phase = phase + 1;
        CE = (!ce_hold && (phase % 4 == 3)) ? 1'b1 : 1'b0;
    endtask

    task automatic push(input string p, input string e, input string o);
        exp_q0.push_back(p);
        exp_q1.push_back(e);
        exp_q2.push_back(o);
    endtask

    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        load = 1'b1;
        D = d;
        while (!(CE && (&ready_w)) && n < 64) begin
            step();
            n++;
        end
        check("send_accept", {31'd0, n < 64}, 32'd1);
        step();
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (((|busy_w) || (|done_w)) && n < 400);
        check("wait_idle", {31'd0, n < 400}, 32'd1);
    endtask

    // Monitor: frame closes on done, bits appended once per CE interval while busy.
    always @(posedge clk_n) begin
        for (int i = 0; i < 3; i++) begin
            if (done_w[i]) begin
                tests++;
                if (done_prev[i]) begin
                    fails++;
                    $display("FAIL done_width dut%0d: got 2+ cycles, required 1", i);
                end
                mon_have = 1'b1;
                case (i)
                    0: if (exp_q0.size() == 0) mon_have = 1'b0; else mon_exp = exp_q0.pop_front();
                    1: if (exp_q1.size() == 0) mon_have = 1'b0; else mon_exp = exp_q1.pop_front();
                    default: if (exp_q2.size() == 0) mon_have = 1'b0; else mon_exp = exp_q2.pop_front();
                endcase
                tests++;
                if (!mon_have) begin
                    fails++;
                    $display("FAIL frame dut%0d: got %s, required no frame", i, got[i]);
                end else if (got[i] != mon_exp) begin
                    fails++;
                    $display("FAIL frame dut%0d: got %s, required %s", i, got[i], mon_exp);
                end
                got[i] = "";
            end
            if (!busy_w[i]) got[i] = "";
            else if (CE) begin
                if (ser_w[i]) got[i] = {got[i], "1"};
                else got[i] = {got[i], "0"};
            end
        end
        done_prev = done_w;
    end

    initial begin
        logic [2:0] ref_ser;
        logic       ok;
        int         n;
        CE = 1'b0;
        load = 1'b0;
        D = 8'h00;
        #1 clr_n = 1'b0;
        #1;
        check("reset_pre_edge", {20'd0, ser_w, ready_w, busy_w, done_w}, {20'd0, 3'b111, 3'b111, 3'b000, 3'b000});
        for (int k = 0; k < 3; k++) begin
            step();
            check("reset_held", {20'd0, ser_w, ready_w, busy_w, done_w}, {20'd0, 3'b111, 3'b111, 3'b000, 3'b000});
        end
        clr_n = 1'b1;
        step();
        check("idle_after_reset", {20'd0, ser_w, ready_w, busy_w, done_w}, {20'd0, 3'b111, 3'b111, 3'b000, 3'b000});

        // Basic and parity frames
        push("0101001011", "01010010101", "01010010111");
        send(8'hA5);
        wait_idle();
        check("return_idle", {23'd0, ser_w, ready_w, busy_w}, {23'd0, 3'b111, 3'b111, 3'b000});
        push("0111000001", "01110000011", "01110000001");
        send(8'h07);
        wait_idle();

        // Back-to-back: load held with the second word through STOP
        push("0001111001", "00011110001", "00011110011");
        push("0110000111", "01100001101", "01100001111");
        load = 1'b1;
        D = 8'h3C;
        n = 0;
        while (!(CE && (&ready_w)) && n < 64) begin step(); n++; end
        step();
        D = 8'hC3;
        n = 0;
        while (!(CE && ready_w[1]) && n < 200) begin step(); n++; end
        check("b2b_reach_stop", {31'd0, n < 200}, 32'd1);
        step();
        check("b2b_no_gap", {29'd0, busy_w[1], ser_w[1], done_w[1]}, {29'd0, 3'b101});
        load = 1'b0;
        wait_idle();

        // load during DATA is ignored
        push("0000000001", "00000000001", "00000000011");
        send(8'h00);
        repeat (8) step();
        load = 1'b1;
        D = 8'hFF;
        repeat (12) step();
        load = 1'b0;
        D = 8'h00;
        wait_idle();

        // CE held low mid-DATA freezes the line
        push("0010110101", "00101101001", "00101101011");
        send(8'h5A);
        repeat (14) step();
        ce_hold = 1'b1;
        CE = 1'b0;
        ref_ser = ser_w;
        ok = 1'b1;
        repeat (20) begin
            step();
            if (ser_w !== ref_ser || busy_w !== 3'b111 || done_w !== 3'b000) ok = 1'b0;
        end
        check("ce_freeze", {31'd0, ok}, 32'd1);
        ce_hold = 1'b0;
        wait_idle();

        // Asynchronous reset during the 4th data bit
        send(8'hA5);
        repeat (17) step();
        check("pre_reset_busy", {29'd0, busy_w}, {29'd0, 3'b111});
        #1 clr_n = 1'b0;
        #1;
        check("async_reset", {20'd0, ser_w, ready_w, busy_w, done_w}, {20'd0, 3'b111, 3'b111, 3'b000, 3'b000});
        clr_n = 1'b1;
        repeat (3) step();
        push("0100000011", "01000000101", "01000000111");
        send(8'h81);
        wait_idle();

        check("queue0_empty", exp_q0.size(), 32'd0);
        check("queue1_empty", exp_q1.size(), 32'd0);
        check("queue2_empty", exp_q2.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
